axi_burst_mem: RTL and testbench
================================

AXI_BURST_MEM -- requirements
Module: axi_burst_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data bus width in bits (32 or 64).
REQ-002 SHALL have parameter DEPTH_WORDS, default 128, meaning memory size in DATA_WIDTH words.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h44A00000, meaning byte address of word 0.
REQ-004 SHALL have parameter READ_LATENCY, default 2, meaning cycles from AR handshake to first rvalid (0..15).
REQ-005 SHALL have one clock and a synchronous, active-low reset; all logic SHALL use aclk rising edge.
REQ-006 SHALL have the following ports, one per line (name, direction, width, meaning):
  aclk  in  1  clock
  aresetn  in  1  synchronous active-low reset
  awaddr  in  32  write burst start byte address
  awlen  in  8  write beats minus one
  awvalid  in  1  write address valid
  awready  out  1  write address accepted
  wdata  in  DATA_WIDTH  write data
  wstrb  in  DATA_WIDTH/8  byte enables
  wlast  in  1  last write beat
  wvalid  in  1  write data valid
  wready  out  1  write data accepted
  bresp  out  2  write response (00 OKAY, 10 SLVERR)
  bvalid  out  1  write response valid
  bready  in  1  write response accepted
  araddr  in  32  read burst start byte address
  arlen  in  8  read beats minus one
  arvalid  in  1  read address valid
  arready  out  1  read address accepted
  rdata  out  DATA_WIDTH  read data
  rresp  out  2  read response (00 OKAY, 10 SLVERR)
  rlast  out  1  last read beat
  rvalid  out  1  read data valid
  rready  in  1  read data accepted

Function
REQ-007 SHALL support INCR bursts only; word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8), low address bits ignored, index +1 per beat.
REQ-008 SHALL treat a beat as out of range when addr < BASE_ADDR or index >= DEPTH_WORDS (checked per beat, 32-bit unsigned arithmetic).
REQ-009 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; W_IDLE: awready=1, AW handshake latches addr/len -> W_DATA.
REQ-010 W_DATA: wready=1; each W handshake writes only bytes with wstrb=1 to mem[index]; out-of-range beats SHALL NOT write and set sticky error.
REQ-011 On beat number awlen the FSM SHALL go to W_RESP; wlast not equal to (beat==awlen) on any beat SHALL set sticky error.
REQ-012 W_RESP: bvalid=1, bresp=10 if sticky error else 00, held stable until bready; then W_IDLE and error cleared.
REQ-013 Read FSM SHALL have states R_IDLE, R_WAIT, R_DATA; R_IDLE: arready=1, AR handshake latches addr/len.
REQ-014 R_WAIT SHALL last exactly READ_LATENCY cycles, so first rvalid is asserted READ_LATENCY+1 cycles after the AR handshake edge; READ_LATENCY=0 skips R_WAIT.
REQ-015 R_DATA: rvalid=1, rdata=mem[index] (0 and rresp=10 when out of range), rlast=1 on beat arlen; advance on rready; after last beat -> R_IDLE.
REQ-016 rdata/rresp/rlast and bresp SHALL remain stable while valid=1 and ready=0.
REQ-017 Read and write FSMs SHALL run independently; a write committed on edge N SHALL be visible to reads from cycle N+1; a same-cycle read returns old data.
REQ-018 awready/arready SHALL be 0 outside their IDLE states; no new burst is accepted until the current one completes.

Reset
REQ-019 While aresetn=0 at a rising edge: both FSMs -> IDLE, awready=arready=wready=bvalid=rvalid=rlast=0, bresp=rresp=00, rdata=0, sticky error cleared; memory contents SHALL be preserved; reset mid-burst abandons the burst with no response.

Verification
REQ-020 Single write addr BASE+0x8, data 0x7, wstrb=F, then read it back -> bresp=00, rdata=0x7, rlast=1, rvalid exactly 3 cycles after AR handshake (latency 2).
REQ-021 Write burst awlen=3 at BASE with data 1..4, rready toggled 1/0 on read burst arlen=3 -> rdata 1,2,3,4 in order, held while rready=0, rlast only on 4th.
REQ-022 Write wstrb=0001 data 0xAABBCCDD over word 0x11223344 -> word reads 0x112233DD.
REQ-023 Read at BASE+4*DEPTH_WORDS and burst crossing end -> in-range beats OKAY, out-of-range beats rdata=0 rresp=10; write beyond end -> bresp=10, memory unchanged.
REQ-024 Write awlen=1 with wlast=1 on first beat -> bresp=10; assert aresetn=0 mid read burst -> rvalid=0 next cycle, arready=1 one cycle after release, prior memory data intact.

Source files
------------

// File: rtl/axi_burst_mem.sv
// AXI4-style INCR-burst memory slave with independent read and write channels.
// Reads use a programmable latency; the read beat register keeps rdata/rresp/rlast
// stable under back-pressure and isolates them from concurrent writes.
module axi_burst_mem #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH_WORDS  = 128,
  parameter logic [31:0] BASE_ADDR    = 32'h44A0_0000,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [31:0]             awaddr,
  input  logic [7:0]              awlen,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [31:0]             araddr,
  input  logic [7:0]              arlen,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned NB         = DATA_WIDTH / 8;
  localparam int unsigned SH         = $clog2(NB);
  localparam int unsigned IW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] BEAT_BYTES = 32'(NB);
  localparam logic [31:0] DEPTH32    = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  // Beat address check in plain 32-bit unsigned arithmetic.
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> SH) < DEPTH32);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE_ADDR) >> SH;
    return off[IW-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  // Holds the ready outputs low for the first cycle after reset release.
  logic        en_q;
  logic [31:0] waddr_q, raddr_q;
  logic [7:0]  wlen_q, wbeat_q, rlen_q, rbeat_q;
  logic        werr_q;
  logic [3:0]  lat_q;
  logic                  rvalid_q, rlast_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic aw_hs, w_hs, b_hs, ar_hs, w_last_beat, w_inr, r_inr, fetch, r_done;

  assign aw_hs       = awvalid & awready;
  assign w_hs        = wvalid & wready;
  assign b_hs        = bvalid & bready;
  assign ar_hs       = arvalid & arready;
  assign w_last_beat = (wbeat_q == wlen_q);
  assign w_inr       = in_range(waddr_q);
  assign r_inr       = in_range(raddr_q);
  // Load the beat register when it is empty or its current non-last beat is taken.
  assign fetch       = (r_state_q == R_DATA) && (!rvalid_q || (rready && !rlast_q));
  assign r_done      = rvalid_q & rready & rlast_q;

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rlast  = rlast_q;

  // Write FSM state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) w_state_q <= W_IDLE;
    else          w_state_q <= w_state_d;
  end

  // Write FSM next state.
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_d = W_RESP;
      W_RESP:  if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel outputs decoded from state.
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    unique case (w_state_q)
      W_IDLE: awready = en_q;
      W_DATA: wready  = 1'b1;
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = werr_q ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  // Write burst tracking and sticky error.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      en_q    <= 1'b0;
      waddr_q <= '0;
      wlen_q  <= '0;
      wbeat_q <= '0;
      werr_q  <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (aw_hs) begin
        waddr_q <= awaddr;
        wlen_q  <= awlen;
        wbeat_q <= '0;
        werr_q  <= 1'b0;
      end
      if (w_hs) begin
        if (!w_inr || (wlast != w_last_beat)) werr_q <= 1'b1;
        waddr_q <= waddr_q + BEAT_BYTES;
        wbeat_q <= wbeat_q + 8'd1;
      end
      if (b_hs) werr_q <= 1'b0;
    end
  end

  // Byte-masked memory write; contents are never reset.
  always_ff @(posedge aclk) begin
    if (aresetn && w_hs && w_inr) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[word_idx(waddr_q)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) r_state_q <= R_IDLE;
    else          r_state_q <= r_state_d;
  end

  // Read FSM next state.
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = (READ_LATENCY == 0) ? R_DATA : R_WAIT;
      R_WAIT:  if (lat_q == 4'd1) r_state_d = R_DATA;
      R_DATA:  if (r_done) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read address channel output decoded from state.
  always_comb begin
    arready = 1'b0;
    if (r_state_q == R_IDLE) arready = en_q;
  end

  // Read burst tracking, latency counter and registered read beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      raddr_q  <= '0;
      rlen_q   <= '0;
      rbeat_q  <= '0;
      lat_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
      rlast_q  <= 1'b0;
    end else begin
      if (ar_hs) begin
        raddr_q <= araddr;
        rlen_q  <= arlen;
        rbeat_q <= '0;
        lat_q   <= 4'(READ_LATENCY);
      end else if (r_state_q == R_WAIT) begin
        lat_q <= lat_q - 4'd1;
      end
      if (fetch) begin
        rvalid_q <= 1'b1;
        rdata_q  <= r_inr ? mem[word_idx(raddr_q)] : '0;
        rresp_q  <= r_inr ? 2'b00 : 2'b10;
        rlast_q  <= (rbeat_q == rlen_q);
        raddr_q  <= raddr_q + BEAT_BYTES;
        rbeat_q  <= rbeat_q + 8'd1;
      end else if (r_done) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_mem.sv
// Scenario bench for axi_burst_mem: a reference memory model predicts responses
// into queues at stimulus time; each scenario pops and compares what it observed.
module tb_axi_burst_mem;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 128;
  localparam logic [31:0] BASE  = 32'h44A0_0000;
  localparam int unsigned LAT   = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [31:0]   awaddr = '0, araddr = '0;
  logic [7:0]    awlen = '0, arlen = '0;
  logic          awvalid = 1'b0, awready, arvalid = 1'b0, arready;
  logic [DW-1:0] wdata = '0, rdata;
  logic [3:0]    wstrb = '0;
  logic          wlast = 1'b0, wvalid = 1'b0, wready;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready = 1'b0, rlast, rvalid, rready = 1'b0;

  always #5 aclk = ~aclk;

  axi_burst_mem #(
    .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(LAT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct packed {logic [31:0] d; logic [1:0] r; logic l;} beat_t;

  logic [31:0] model [int];
  logic [1:0]  exp_b[$], obs_b[$];
  beat_t       exp_r[$], obs_r[$];
  int          n_cmp = 0, n_bad = 0;
  int          lat_obs, unstable;
  logic        tmo = 1'b0;

  function automatic logic tb_inr(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH));
  endfunction

  // Drives one write burst (data d0, d0+1, ...) and records the observed bresp.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] d0, input logic [3:0] strb, input logic bad_last);
    logic err;
    logic [31:0] a, w, dat;
    int n, idx;
    err = bad_last;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      dat = d0 + 32'(i);
      if (!tb_inr(a)) err = 1'b1;
      else begin
        idx = int'((a - BASE) >> 2);
        w = model.exists(idx) ? model[idx] : '0;
        for (int b = 0; b < 4; b++) if (strb[b]) w[b*8 +: 8] = dat[b*8 +: 8];
        model[idx] = w;
      end
      a = a + 32'd4;
    end
    exp_b.push_back(err ? 2'b10 : 2'b00);
    @(negedge aclk);
    awaddr = addr; awlen = len; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    if (!awready) tmo = 1'b1;
    @(posedge aclk); @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = d0 + 32'(i); wstrb = strb; wvalid = 1'b1;
      wlast = bad_last ? (i == 0) : (i == int'(len));
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      if (!wready) tmo = 1'b1;
      @(posedge aclk); @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    if (!bvalid) tmo = 1'b1;
    obs_b.push_back(bvalid ? bresp : 2'bxx);
    @(posedge aclk); @(negedge aclk);
    bready = 1'b0;
  endtask

  // Drives one read burst; toggle=1 alternates rready. Records beats, latency, stability.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic toggle);
    logic [31:0] a;
    int n, c, beats, idx;
    logic hold;
    beat_t hb, cur;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      idx = int'((a - BASE) >> 2);
      if (tb_inr(a)) exp_r.push_back({model.exists(idx) ? model[idx] : 32'hx, 2'b00, i == int'(len)});
      else           exp_r.push_back({32'h0, 2'b10, i == int'(len)});
      a = a + 32'd4;
    end
    @(negedge aclk);
    araddr = addr; arlen = len; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (!arready) tmo = 1'b1;
    @(posedge aclk); @(negedge aclk);
    arvalid = 1'b0;
    lat_obs = -1; unstable = 0; c = 0; beats = 0; hold = 1'b0; hb = '0;
    while (beats <= int'(len) && c < 200) begin
      cur = {rdata, rresp, rlast};
      if (rvalid && lat_obs < 0) lat_obs = c;
      rready = toggle ? (c % 2 == 1) : 1'b1;
      if (hold && (cur !== hb)) unstable++;
      hold = rvalid && !rready;
      hb = cur;
      if (rvalid && rready) begin obs_r.push_back(cur); beats++; end
      @(posedge aclk); @(negedge aclk);
      c++;
    end
    rready = 1'b0;
    if (beats <= int'(len)) tmo = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    n_cmp++; if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {awready, arready, wready, bvalid, rvalid, rlast});
    end
    n_cmp++; if ({bresp, rresp} !== 4'b0) begin
      n_bad++; $display("FAIL reset_resp: got %b want 0000", {bresp, rresp});
    end
    n_cmp++; if (rdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata);
    end
    aresetn = 1'b1;
    @(posedge aclk); @(negedge aclk);
    n_cmp++; if ({awready, arready} !== 2'b11) begin
      n_bad++; $display("FAIL reset_release_ready: got %b want 11", {awready, arready});
    end
  endtask

  task automatic test_single();
    beat_t e, o;
    logic [1:0] eb, ob;
    do_write(BASE + 32'h8, 8'd0, 32'h7, 4'hF, 1'b0);
    eb = exp_b.pop_front(); ob = obs_b.pop_front();
    n_cmp++; if (ob !== eb || ob !== 2'b00) begin
      n_bad++; $display("FAIL single_bresp: got %b want %b", ob, eb);
    end
    do_read(BASE + 32'h8, 8'd0, 1'b0);
    e = exp_r.pop_front(); o = (obs_r.size() > 0) ? obs_r.pop_front() : 'x;
    n_cmp++; if (o !== e || o !== {32'h7, 2'b00, 1'b1}) begin
      n_bad++; $display("FAIL single_read: got %h/%b/%b want %h/%b/%b", o.d, o.r, o.l, e.d, e.r, e.l);
    end
    n_cmp++; if (lat_obs !== int'(LAT) + 1) begin
      n_bad++; $display("FAIL single_latency: got %0d want %0d", lat_obs, LAT + 1);
    end
  endtask

  task automatic test_burst_backpressure();
    beat_t e, o;
    logic [1:0] eb, ob;
    do_write(BASE, 8'd3, 32'h1, 4'hF, 1'b0);
    eb = exp_b.pop_front(); ob = obs_b.pop_front();
    n_cmp++; if (ob !== eb) begin n_bad++; $display("FAIL burst_bresp: got %b want %b", ob, eb); end
    do_read(BASE, 8'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      e = exp_r.pop_front(); o = (obs_r.size() > 0) ? obs_r.pop_front() : 'x;
      n_cmp++; if (o !== e || o.d !== 32'(i + 1)) begin
        n_bad++; $display("FAIL burst_beat%0d: got %h/%b/%b want %h/%b/%b", i, o.d, o.r, o.l, e.d, e.r, e.l);
      end
    end
    n_cmp++; if (unstable !== 0) begin
      n_bad++; $display("FAIL burst_hold_stable: got %0d changes want 0", unstable);
    end
  endtask

  task automatic test_strobe();
    beat_t e, o;
    logic [1:0] eb, ob;
    do_write(BASE + 32'h40, 8'd0, 32'h1122_3344, 4'hF, 1'b0);
    do_write(BASE + 32'h40, 8'd0, 32'hAABB_CCDD, 4'b0001, 1'b0);
    for (int i = 0; i < 2; i++) begin
      eb = exp_b.pop_front(); ob = obs_b.pop_front();
      n_cmp++; if (ob !== eb) begin n_bad++; $display("FAIL strobe_bresp%0d: got %b want %b", i, ob, eb); end
    end
    do_read(BASE + 32'h40, 8'd0, 1'b0);
    e = exp_r.pop_front(); o = (obs_r.size() > 0) ? obs_r.pop_front() : 'x;
    n_cmp++; if (o !== e || o.d !== 32'h1122_33DD) begin
      n_bad++; $display("FAIL strobe_read: got %h want %h", o.d, e.d);
    end
  endtask

  task automatic test_out_of_range();
    beat_t e, o;
    logic [1:0] eb, ob;
    do_write(BASE + 32'(4 * (DEPTH - 2)), 8'd1, 32'hCAFE_0000, 4'hF, 1'b0);
    do_write(BASE + 32'(4 * DEPTH), 8'd0, 32'hDEAD_BEEF, 4'hF, 1'b0);
    do_write(BASE - 32'd4, 8'd0, 32'hDEAD_BEEF, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      eb = exp_b.pop_front(); ob = obs_b.pop_front();
      n_cmp++; if (ob !== eb) begin n_bad++; $display("FAIL oor_bresp%0d: got %b want %b", i, ob, eb); end
    end
    do_read(BASE + 32'(4 * DEPTH), 8'd0, 1'b0);
    do_read(BASE + 32'(4 * (DEPTH - 2)), 8'd3, 1'b0);
    do_read(BASE, 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      e = exp_r.pop_front(); o = (obs_r.size() > 0) ? obs_r.pop_front() : 'x;
      n_cmp++; if (o !== e) begin
        n_bad++; $display("FAIL oor_beat%0d: got %h/%b/%b want %h/%b/%b", i, o.d, o.r, o.l, e.d, e.r, e.l);
      end
    end
  endtask

  task automatic test_wlast_err();
    beat_t e, o;
    logic [1:0] eb, ob;
    do_write(BASE + 32'h80, 8'd1, 32'h0000_5A00, 4'hF, 1'b1);
    eb = exp_b.pop_front(); ob = obs_b.pop_front();
    n_cmp++; if (ob !== eb || ob !== 2'b10) begin
      n_bad++; $display("FAIL wlast_bresp: got %b want %b", ob, eb);
    end
    // Next burst must start with a cleared error.
    do_write(BASE + 32'h100, 8'd2, 32'h0000_0100, 4'hF, 1'b0);
    eb = exp_b.pop_front(); ob = obs_b.pop_front();
    n_cmp++; if (ob !== eb) begin n_bad++; $display("FAIL err_cleared_bresp: got %b want %b", ob, eb); end
  endtask

  task automatic test_back_to_back();
    beat_t e, o;
    do_read(BASE + 32'h100, 8'd2, 1'b0);
    do_read(BASE + 32'h80, 8'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      e = exp_r.pop_front(); o = (obs_r.size() > 0) ? obs_r.pop_front() : 'x;
      n_cmp++; if (o !== e) begin
        n_bad++; $display("FAIL b2b_beat%0d: got %h/%b/%b want %h/%b/%b", i, o.d, o.r, o.l, e.d, e.r, e.l);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    beat_t e, o;
    int n;
    @(negedge aclk);
    araddr = BASE; arlen = 8'd3; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    @(posedge aclk); @(negedge aclk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge aclk); n++; end
    n_cmp++; if (rvalid !== 1'b1) begin n_bad++; $display("FAIL midrd_rvalid_before: got %b want 1", rvalid); end
    aresetn = 1'b0;
    @(posedge aclk); @(negedge aclk);
    n_cmp++; if ({rvalid, arready} !== 2'b00) begin
      n_bad++; $display("FAIL midrd_in_reset: got %b want 00", {rvalid, arready});
    end
    aresetn = 1'b1;
    @(posedge aclk); @(negedge aclk);
    n_cmp++; if (arready !== 1'b1) begin n_bad++; $display("FAIL midrd_arready_after: got %b want 1", arready); end
    do_read(BASE, 8'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      e = exp_r.pop_front(); o = (obs_r.size() > 0) ? obs_r.pop_front() : 'x;
      n_cmp++; if (o !== e) begin
        n_bad++; $display("FAIL midrd_mem_beat%0d: got %h want %h", i, o.d, e.d);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_burst_backpressure();
    test_strobe();
    test_out_of_range();
    test_wlast_err();
    test_back_to_back();
    test_reset_mid_read();
    n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL handshake_timeout: got %b want 0", tmo); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
